// File: rtl/netlist_toggle_monitor.sv
// rtl/netlist_toggle_monitor.sv - per-bit toggle counter and window switching-activity monitor
module netlist_toggle_monitor #(
    parameter int WIDTH  = 62,
    parameter int CNT_W  = 16,
    parameter int WINDOW = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     sample_en,
    input  logic [WIDTH-1:0]         dut_out,
    input  logic [$clog2(WIDTH)-1:0] rd_idx,
    output logic [CNT_W-1:0]         rd_cnt,
    output logic [CNT_W+5:0]         total,
    output logic                     busy,
    output logic                     done
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SMP_W = $clog2(WINDOW + 1);
    localparam int TOT_W = CNT_W + 6;

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] ref_q;
    logic [SMP_W-1:0] smp_cnt;
    logic [WIDTH-1:0] diff;
    logic [POP_W-1:0] pop;
    logic [TOT_W:0]   total_sum;
    logic [TOT_W-1:0] total_next;

    // One extra bit on the sum catches overflow so total can clamp instead of wrapping.
    always_comb begin
        diff = dut_out ^ ref_q;
        pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
        total_sum  = {1'b0, total} + (TOT_W+1)'(pop);
        total_next = total_sum[TOT_W] ? {TOT_W{1'b1}} : total_sum[TOT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ref_q   <= '0;
            smp_cnt <= '0;
            total   <= '0;
            rd_cnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rd_cnt <= ({1'b0, rd_idx} < (IDX_W+1)'(WIDTH)) ? cnt[rd_idx] : '0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            cnt[i] <= '0;
                        end
                        total   <= '0;
                        smp_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    if (sample_en) begin
                        ref_q <= dut_out;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (sample_en) begin
                        ref_q <= dut_out;
                        for (int i = 0; i < WIDTH; i++) begin
                            if (diff[i] && (cnt[i] != {CNT_W{1'b1}})) begin
                                cnt[i] <= cnt[i] + 1'b1;
                            end
                        end
                        total   <= total_next;
                        smp_cnt <= smp_cnt + 1'b1;
                        // The closing sample's toggles are kept; DONE follows on this edge.
                        if (smp_cnt == SMP_W'(WINDOW - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_netlist_toggle_monitor.sv
// tb/tb_netlist_toggle_monitor.sv - self-checking bench for netlist_toggle_monitor
module tb_netlist_toggle_monitor;
    localparam int W = 62;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           gap;
        int           c0;
        int           c1;
        int           c61;
        int           tot;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         sample_en = 1'b0;
    logic [W-1:0] dut_out = '0;
    logic [5:0]   rd_idx = '0;
    logic [3:0]   rd_cnt_m, rd_cnt_s;
    logic [9:0]   total_m, total_s;
    logic         busy_m, done_m, busy_s, done_s;
    int           checks = 0;
    int           errors = 0;
    vec_t         vecs [5];

    always #5 clk = ~clk;

    netlist_toggle_monitor #(.WIDTH(W), .CNT_W(4), .WINDOW(4)) dut_m (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .dut_out(dut_out),
        .rd_idx(rd_idx), .rd_cnt(rd_cnt_m), .total(total_m), .busy(busy_m), .done(done_m)
    );

    netlist_toggle_monitor #(.WIDTH(W), .CNT_W(4), .WINDOW(20)) dut_s (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .dut_out(dut_out),
        .rd_idx(rd_idx), .rd_cnt(rd_cnt_s), .total(total_s), .busy(busy_s), .done(done_s)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_bus();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] onehot(input int n);
        logic [W-1:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input logic [W-1:0] v);
        dut_out   = v;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        dut_out   = rand_bus();
    endtask

    task automatic read_cnt(input int idx);
        rd_idx = 6'(idx);
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        pulse_start();
        check({v.name, "_busy_arm"}, busy_m, 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    dut_out = rand_bus();
                    tick();
                end
            end
            sample((k % 2) ? v.b : v.a);
            if (k == 3) check({v.name, "_no_early_done"}, done_m, 0);
        end
        check({v.name, "_done"}, done_m, 1);
        check({v.name, "_busy_low"}, busy_m, 0);
        tick();
        check({v.name, "_done_one_cycle"}, done_m, 0);
        read_cnt(0);  check({v.name, "_cnt0"}, rd_cnt_m, v.c0);
        read_cnt(1);  check({v.name, "_cnt1"}, rd_cnt_m, v.c1);
        read_cnt(61); check({v.name, "_cnt61"}, rd_cnt_m, v.c61);
        check({v.name, "_total"}, total_m, v.tot);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] alt;
        logic [W-1:0] s [5];
        int           exp_cnt [W];
        int           raw_sum;
        int           exp_tot;

        alt = {31{2'b10}};
        vecs[0] = '{"walk_bit0", {W{1'b0}}, onehot(0), 0, 4, 0, 0, 4};
        vecs[1] = '{"all_flip_gap2", {W{1'b0}}, {W{1'b1}}, 2, 4, 4, 4, 248};
        vecs[2] = '{"bits_1_61_gap1", {W{1'b0}}, onehot(1) | onehot(61), 1, 0, 4, 4, 8};
        vecs[3] = '{"static_ones", {W{1'b1}}, {W{1'b1}}, 0, 0, 0, 0, 0};
        vecs[4] = '{"checker_flip", alt, ~alt, 1, 4, 4, 4, 248};

        // reset held with start and sample_en active
        rst = 1'b0; start = 1'b1; sample_en = 1'b1; dut_out = rand_bus();
        repeat (3) tick();
        check("rst_busy", busy_m, 0);
        check("rst_done", done_m, 0);
        check("rst_total", total_m, 0);
        check("rst_busy_s", busy_s, 0);
        for (int i = 0; i < 64; i++) begin
            dut_out = rand_bus();
            read_cnt(i);
            check("rst_rd_cnt", rd_cnt_m, 0);
        end
        rst = 1'b1; start = 1'b0; sample_en = 1'b0;
        tick();
        check("post_rst_busy", busy_m, 0);

        // saturation on the 20-sample instance
        pulse_start();
        for (int k = 0; k < 21; k++) sample((k % 2) ? onehot(5) : {W{1'b0}});
        check("sat_done", done_s, 1);
        read_cnt(5); check("sat_cnt5", rd_cnt_s, 15);
        read_cnt(4); check("sat_cnt4", rd_cnt_s, 0);
        check("sat_total", total_s, 20);
        pulse_start();
        for (int k = 0; k < 21; k++) sample((k % 2) ? {W{1'b1}} : {W{1'b0}});
        check("sat_all_done", done_s, 1);
        read_cnt(0);  check("sat_all_cnt0", rd_cnt_s, 15);
        read_cnt(30); check("sat_all_cnt30", rd_cnt_s, 15);
        read_cnt(61); check("sat_all_cnt61", rd_cnt_s, 15);
        check("sat_all_total", total_s, 1023);

        for (int v = 0; v < 5; v++) run_vec(vecs[v]);

        // readout latency and out-of-range index, with every counter at 4
        read_cnt(0);
        check("lat_idx0", rd_cnt_m, 4);
        rd_idx = 6'd62;
        #1;
        check("lat_old_value", rd_cnt_m, 4);
        tick();
        check("lat_idx62", rd_cnt_m, 0);
        read_cnt(63); check("lat_idx63", rd_cnt_m, 0);
        read_cnt(10); check("lat_idx10", rd_cnt_m, 4);

        // start in COUNT is ignored
        pulse_start();
        sample({W{1'b0}}); sample(onehot(2)); sample({W{1'b0}});
        pulse_start();
        check("ign_busy", busy_m, 1);
        check("ign_done", done_m, 0);
        sample(onehot(2));
        check("ign_no_early_done", done_m, 0);
        sample({W{1'b0}});
        check("ign_done_at_4th", done_m, 1);
        read_cnt(2); check("ign_cnt2", rd_cnt_m, 4);
        check("ign_total", total_m, 4);

        // new start clears the previous results
        pulse_start();
        read_cnt(2); check("clr_cnt2", rd_cnt_m, 0);
        check("clr_total", total_m, 0);
        check("clr_busy", busy_m, 1);

        // reset mid-window
        sample({W{1'b0}}); sample(onehot(3)); sample({W{1'b0}});
        read_cnt(3); check("mid_cnt3_live", rd_cnt_m, 2);
        check("mid_total_live", total_m, 2);
        rst = 1'b0;
        #1;
        check("mid_rst_async_busy", busy_m, 0);
        check("mid_rst_async_rd", rd_cnt_m, 0);
        tick();
        rst = 1'b1;
        read_cnt(3); check("mid_cnt3_cleared", rd_cnt_m, 0);
        sample(onehot(3)); sample({W{1'b0}}); sample(onehot(3));
        read_cnt(3); check("mid_no_count_without_start", rd_cnt_m, 0);
        check("mid_idle_busy", busy_m, 0);
        read_cnt(62); check("mid_idx62", rd_cnt_m, 0);

        // randomized windows against a toggle-counting model
        for (int w = 0; w < 8; w++) begin
            s[0] = rand_bus();
            for (int k = 1; k < 5; k++) s[k] = s[k-1] ^ (rand_bus() & rand_bus());
            pulse_start();
            for (int k = 0; k < 5; k++) begin
                if (k > 0) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                        dut_out = rand_bus();
                        start   = 1'($urandom_range(0, 1));
                        rd_idx  = 6'($urandom_range(0, 63));
                        tick();
                        start   = 1'b0;
                    end
                end
                sample(s[k]);
            end
            check("rnd_done", done_m, 1);
            raw_sum = 0;
            for (int i = 0; i < W; i++) begin
                exp_cnt[i] = 0;
                for (int k = 0; k < 4; k++) if (s[k][i] != s[k+1][i]) exp_cnt[i]++;
                raw_sum += exp_cnt[i];
                if (exp_cnt[i] > 15) exp_cnt[i] = 15;
            end
            exp_tot = (raw_sum > 1023) ? 1023 : raw_sum;
            for (int i = 0; i < W; i++) begin
                read_cnt(i);
                check("rnd_cnt", rd_cnt_m, exp_cnt[i]);
            end
            check("rnd_total", total_m, exp_tot);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
